skewed_input_router: RTL

Parametrised successor to the input routing stage: captures SPAD words into per-row lane FIFOs using programmable address windows, then drains all lanes into the PE array rows with a one-cycle-per-row systolic skew. Each drained element is emitted at the precision selected by a mode input. It sits between the tile reader and the PE array.

---
 rtl/skewed_input_router.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/skewed_input_router.sv
// Captures SPAD words into per-row lane FIFOs by address window, then drains every lane
// into its PE row with a one-cycle-per-row skew, serialised at 8/4/2-bit precision.
module skewed_input_router #(
    parameter int DATA_WIDTH      = 8,
    parameter int SPAD_DATA_WIDTH = 64,
    parameter int SPAD_N          = SPAD_DATA_WIDTH / DATA_WIDTH,
    parameter int ADDR_WIDTH      = 8,
    parameter int ROWS            = 4,
    parameter int FIFO_DEPTH      = 16,
    parameter int ID_WIDTH        = $clog2(ROWS)
) (
    input  logic                           i_clk,
    input  logic                           i_nrst,
    input  logic                           i_reg_clear,
    input  logic                           i_cfg_we,
    input  logic [ID_WIDTH-1:0]            i_cfg_id,
    input  logic [ADDR_WIDTH-1:0]          i_cfg_start,
    input  logic [ADDR_WIDTH-1:0]          i_cfg_end,
    input  logic [ROWS-1:0]                i_row_mask,
    input  logic [SPAD_DATA_WIDTH-1:0]     i_data,
    input  logic [ADDR_WIDTH-1:0]          i_addr,
    input  logic                           i_data_valid,
    output logic                           o_data_ready,
    input  logic                           i_pop_en,
    input  logic [1:0]                     i_p_mode,
    output logic [ROWS*DATA_WIDTH-1:0]     o_data,
    output logic [ROWS-1:0]                o_data_valid,
    output logic [ROWS-1:0]                o_fifo_full,
    output logic [ROWS-1:0]                o_fifo_empty,
    output logic                           o_ready,
    output logic                           o_done
);
    localparam int IDX_W = $clog2(SPAD_N * 4);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int E_W   = $clog2(ROWS + 1);
    localparam int SH_W  = $clog2(SPAD_DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAIN = 2'd1, S_DONE = 2'd2} state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 mode_q, mode_d;
    logic [E_W-1:0]             elapsed_q, elapsed_d;
    logic                       done_q, done_d;
    logic [ADDR_WIDTH-1:0]      win_start_q [ROWS];
    logic [ADDR_WIDTH-1:0]      win_end_q   [ROWS];
    logic [PTR_W:0]             wr_ptr_q [ROWS];
    logic [PTR_W:0]             wr_ptr_d [ROWS];
    logic [PTR_W:0]             rd_ptr_q [ROWS];
    logic [PTR_W:0]             rd_ptr_d [ROWS];
    logic [IDX_W-1:0]           idx_q [ROWS];
    logic [IDX_W-1:0]           idx_d [ROWS];
    logic [DATA_WIDTH-1:0]      data_q [ROWS];
    logic [DATA_WIDTH-1:0]      data_d [ROWS];
    logic [ROWS-1:0]            valid_q, valid_d;
    logic [SPAD_DATA_WIDTH-1:0] mem_q [ROWS][FIFO_DEPTH];

    logic [ROWS-1:0]            hit_s, full_s, empty_s, push_s, emit_s;
    logic                       ready_s, start_s, run_s;
    logic [1:0]                 eff_mode_s;
    logic [E_W-1:0]             cur_e_s;
    logic [IDX_W-1:0]           last_idx_s;
    logic [SPAD_DATA_WIDTH-1:0] shifted_s [ROWS];
    logic [SH_W-1:0]            shamt_s [ROWS];
    logic [DATA_WIDTH-1:0]      low_s [ROWS];
    logic [DATA_WIDTH-1:0]      elem_s [ROWS];
    int                         sext_s;

    // Window hit, lane status, capture handshake and drain control decode
    always_comb begin
        ready_s    = 1'b0;
        start_s    = (state_q == S_IDLE) && i_pop_en;
        run_s      = start_s || (state_q == S_DRAIN);
        // The pop cycle itself already emits lane 0, so it must see the incoming mode
        eff_mode_s = start_s ? ((i_p_mode == 2'd3) ? 2'd0 : i_p_mode) : mode_q;
        cur_e_s    = start_s ? '0 : elapsed_q;
        last_idx_s = IDX_W'((SPAD_N << eff_mode_s) - 1);
        sext_s     = DATA_WIDTH - (DATA_WIDTH >> eff_mode_s);
        for (int r = 0; r < ROWS; r++) begin
            hit_s[r]   = i_row_mask[r] && (win_start_q[r] <= i_addr) && (i_addr <= win_end_q[r]);
            empty_s[r] = (wr_ptr_q[r] == rd_ptr_q[r]);
            full_s[r]  = ((wr_ptr_q[r] - rd_ptr_q[r]) == (PTR_W+1)'(FIFO_DEPTH));
        end
        ready_s = (state_q == S_IDLE) && !(|(hit_s & full_s));
        for (int r = 0; r < ROWS; r++) begin
            push_s[r]    = i_data_valid && ready_s && hit_s[r];
            emit_s[r]    = run_s && (int'(cur_e_s) >= r) && !empty_s[r];
            shamt_s[r]   = SH_W'(int'(idx_q[r]) * (DATA_WIDTH >> eff_mode_s));
            shifted_s[r] = mem_q[r][rd_ptr_q[r][PTR_W-1:0]] >> shamt_s[r];
            low_s[r]     = shifted_s[r][DATA_WIDTH-1:0] << sext_s;
            elem_s[r]    = DATA_WIDTH'($signed(low_s[r]) >>> sext_s);
        end
    end

    // Next-state for FSM, FIFO pointers, serialisers and row output registers
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        elapsed_d = elapsed_q;
        done_d    = 1'b0;
        valid_d   = '0;
        for (int r = 0; r < ROWS; r++) begin
            wr_ptr_d[r] = wr_ptr_q[r] + ((PTR_W+1)'(push_s[r]));
            rd_ptr_d[r] = rd_ptr_q[r];
            idx_d[r]    = idx_q[r];
            data_d[r]   = '0;
            if (emit_s[r]) begin
                valid_d[r] = 1'b1;
                data_d[r]  = elem_s[r];
                if (idx_q[r] == last_idx_s) begin
                    idx_d[r]    = '0;
                    rd_ptr_d[r] = rd_ptr_q[r] + (PTR_W+1)'(1);
                end else begin
                    idx_d[r] = idx_q[r] + IDX_W'(1);
                end
            end else begin
                idx_d[r] = idx_q[r];
            end
        end
        case (state_q)
            S_IDLE: begin
                if (i_pop_en) begin
                    state_d   = S_DRAIN;
                    mode_d    = eff_mode_s;
                    elapsed_d = E_W'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (elapsed_q < E_W'(ROWS)) begin
                    elapsed_d = elapsed_q + E_W'(1);
                end else begin
                    elapsed_d = elapsed_q;
                end
                // Lane r cannot have started before elapsed reaches r, so empty + full skew means finished
                if ((&empty_s) && (elapsed_q >= E_W'(ROWS))) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and control registers; soft clear behaves like reset except for windows
    always_ff @(posedge i_clk) begin
        if (!i_nrst || i_reg_clear) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'd0;
            elapsed_q <= '0;
            done_q    <= 1'b0;
            valid_q   <= '0;
            for (int r = 0; r < ROWS; r++) begin
                wr_ptr_q[r] <= '0;
                rd_ptr_q[r] <= '0;
                idx_q[r]    <= '0;
                data_q[r]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            elapsed_q <= elapsed_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            for (int r = 0; r < ROWS; r++) begin
                wr_ptr_q[r] <= wr_ptr_d[r];
                rd_ptr_q[r] <= rd_ptr_d[r];
                idx_q[r]    <= idx_d[r];
                data_q[r]   <= data_d[r];
            end
        end
    end

    // Address window registers, reset to a never-hit window
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            for (int r = 0; r < ROWS; r++) begin
                win_start_q[r] <= '1;
                win_end_q[r]   <= '0;
            end
        end else if (i_cfg_we && (int'(i_cfg_id) < ROWS)) begin
            win_start_q[i_cfg_id] <= i_cfg_start;
            win_end_q[i_cfg_id]   <= i_cfg_end;
        end
    end

    // Lane FIFO storage
    always_ff @(posedge i_clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (push_s[r]) begin
                mem_q[r][wr_ptr_q[r][PTR_W-1:0]] <= i_data;
            end
        end
    end

    // Output mapping
    always_comb begin
        o_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            o_data[r*DATA_WIDTH +: DATA_WIDTH] = data_q[r];
        end
        o_data_valid = valid_q;
        o_fifo_full  = full_s;
        o_fifo_empty = empty_s;
        o_data_ready = ready_s;
        o_ready      = (state_q == S_IDLE);
        o_done       = done_q;
    end
endmodule
